// File: rtl/inference_feeder.sv
// Host-side feeder for the systolic inference datapath: takes one job command,
// buffers 8 weight rows and issues them back-to-back, streams N input rows,
// flushes the array and collects activations into a small result FIFO.
module inference_feeder #(
  parameter int unsigned ARRAY_DIM = 8,
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_start,
  input  logic [6:0]        cmd_num_inputs,
  input  logic [WORD_W-1:0] cmd_bias,
  input  logic [1:0]        cmd_mode,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic [WORD_W-1:0] systolic_data,
  output logic [WORD_W-1:0] bias_vec,
  output logic [1:0]        activation_mode,
  output logic              start_weights,
  output logic              start_array,
  output logic              enable,
  input  logic [WORD_W-1:0] activations,
  input  logic              activated,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [WORD_W-1:0] r_data
);

  localparam int unsigned WIW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int unsigned PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] LP_ROOM2 = CW'(OUT_DEPTH - 2);
  localparam logic [CW-1:0] LP_FULL  = CW'(OUT_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WFILL, S_WISSUE, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [6:0]         r_n, r_in_cnt, r_res_cnt;
  logic [WIW-1:0]     r_widx;
  logic [WORD_W-1:0]  r_wbuf [ARRAY_DIM];
  logic [WORD_W-1:0]  r_bias, r_sys;
  logic [1:0]         r_mode;
  logic               r_busy, r_done, r_ovf, r_en, r_sw, r_sa;
  logic [WORD_W-1:0]  r_mem [OUT_DEPTH];
  logic [PW-1:0]      r_rd, r_wr;
  logic [CW-1:0]      r_cnt;

  logic w_s_ready, w_start, w_last_w, w_last_in, w_room2;
  logic w_full, w_empty, w_pop, w_push, w_drop, w_in_fire;

  // Two free slots are needed because one result may already be in flight
  // between the registered enable and the capture edge.
  assign w_room2   = (r_cnt <= LP_ROOM2);
  assign w_full    = (r_cnt == LP_FULL);
  assign w_empty   = (r_cnt == '0);
  assign w_pop     = !w_empty && r_ready;
  assign w_push    = activated && (!w_full || w_pop);
  assign w_drop    = activated && w_full && !w_pop;
  assign w_start   = (r_state == S_IDLE) && cmd_start && (cmd_num_inputs != '0);
  assign w_last_w  = (r_widx == WIW'(ARRAY_DIM - 1));
  assign w_last_in = (r_in_cnt == (r_n - 7'd1));
  assign w_in_fire = (r_state == S_STREAM) && s_valid && w_room2;

  // Next-state and stream-side ready
  always_comb begin
    w_next    = r_state;
    w_s_ready = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_WFILL;
      S_WFILL: begin
        w_s_ready = 1'b1;
        if (s_valid && w_last_w) w_next = S_WISSUE;
      end
      S_WISSUE: if (w_last_w) w_next = S_STREAM;
      S_STREAM: begin
        w_s_ready = w_room2;
        if (w_in_fire && w_last_in) w_next = S_DRAIN;
      end
      S_DRAIN:  if (r_res_cnt == r_n) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register plus busy/done, both registered from the next state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_next inside {S_WFILL, S_WISSUE, S_STREAM, S_DRAIN};
      r_done  <= (w_next == S_DONE);
    end
  end

  // Job parameters, weight buffer and progress counters
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_n       <= '0;
      r_in_cnt  <= '0;
      r_res_cnt <= '0;
      r_widx    <= '0;
      r_wbuf    <= '{default: '0};
      r_bias    <= '0;
      r_mode    <= '0;
    end else begin
      if (w_start) begin
        r_n       <= cmd_num_inputs;
        r_bias    <= cmd_bias;
        r_mode    <= cmd_mode;
        r_in_cnt  <= '0;
        r_res_cnt <= '0;
        r_widx    <= '0;
      end
      if (r_state == S_WFILL && s_valid) begin
        r_wbuf[r_widx] <= s_data;
        r_widx         <= w_last_w ? '0 : r_widx + 1'b1;
      end
      if (r_state == S_WISSUE) r_widx <= w_last_w ? '0 : r_widx + 1'b1;
      if (w_in_fire) r_in_cnt <= r_in_cnt + 7'd1;
      if (activated && r_state != S_IDLE && r_res_cnt != r_n)
        r_res_cnt <= r_res_cnt + 7'd1;
    end
  end

  // Registered datapath-facing row, enable and start pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sys <= '0;
      r_en  <= 1'b0;
      r_sw  <= 1'b0;
      r_sa  <= 1'b0;
    end else begin
      r_en <= 1'b0;
      r_sw <= 1'b0;
      r_sa <= 1'b0;
      case (r_state)
        S_WISSUE: begin
          r_en  <= 1'b1;
          r_sys <= r_wbuf[r_widx];
          r_sw  <= (r_widx == '0);
        end
        S_STREAM: if (w_in_fire) begin
          r_en  <= 1'b1;
          r_sys <= s_data;
          r_sa  <= (r_in_cnt == '0);
        end
        S_DRAIN: if (w_room2 && r_res_cnt != r_n) begin
          r_en  <= 1'b1;
          r_sys <= '0;
        end
        default: ;
      endcase
    end
  end

  // Result FIFO with sticky overflow; a full FIFO still accepts a push that
  // coincides with a pop
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mem <= '{default: '0};
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= activations;
        r_wr        <= (r_wr == PW'(OUT_DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == PW'(OUT_DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_start) r_ovf <= 1'b0;
      if (w_drop)  r_ovf <= 1'b1;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign overflow        = r_ovf;
  assign s_ready         = w_s_ready;
  assign systolic_data   = r_sys;
  assign bias_vec        = r_bias;
  assign activation_mode = r_mode;
  assign start_weights   = r_sw;
  assign start_array     = r_sa;
  assign enable          = r_en;
  assign r_valid         = !w_empty;
  assign r_data          = r_mem[r_rd];

endmodule

// File: tb/tb_inference_feeder.sv
// Bench for inference_feeder: an enable-gated pipeline stands in for the
// datapath; expected rows and results are derived from the job contents.
module tb_inference_feeder;
  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [6:0]  cmd_num_inputs = '0;
  logic [63:0] cmd_bias = '0;
  logic [1:0]  cmd_mode = '0;
  logic        busy, done, overflow;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic [63:0] systolic_data, bias_vec;
  logic [1:0]  activation_mode;
  logic        start_weights, start_array, enable;
  logic [63:0] activations;
  logic        activated;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [63:0] r_data;

  always #5 clk = ~clk;

  inference_feeder #(.ARRAY_DIM(8), .WORD_W(64), .OUT_DEPTH(4)) dut (
    .clk(clk), .n_rst(n_rst), .cmd_start(cmd_start), .cmd_num_inputs(cmd_num_inputs),
    .cmd_bias(cmd_bias), .cmd_mode(cmd_mode), .busy(busy), .done(done), .overflow(overflow),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .systolic_data(systolic_data),
    .bias_vec(bias_vec), .activation_mode(activation_mode), .start_weights(start_weights),
    .start_array(start_array), .enable(enable), .activations(activations),
    .activated(activated), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
  );

  function automatic logic [63:0] act_fn(input logic [63:0] x);
    return {x[55:0], x[63:56]} ^ 64'h5A5A_5A5A_5A5A_5A5A;
  endfunction

  // Datapath stand-in: rows advance only on enable; the first cur_n rows
  // starting at start_array are real inputs, everything else is untagged.
  logic [63:0] p_d [LAT];
  logic        p_v [LAT];
  int          rem;
  int          cur_n = 0;
  logic        inj_act = 1'b0;
  logic [63:0] inj_data = '0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < LAT; i++) begin p_v[i] <= 1'b0; p_d[i] <= '0; end
      rem <= 0;
    end else if (enable) begin
      for (int i = LAT - 1; i > 0; i--) begin p_v[i] <= p_v[i-1]; p_d[i] <= p_d[i-1]; end
      p_d[0] <= systolic_data;
      if (start_array) begin p_v[0] <= 1'b1; rem <= cur_n - 1; end
      else if (rem > 0) begin p_v[0] <= 1'b1; rem <= rem - 1; end
      else p_v[0] <= 1'b0;
    end
  end

  assign activated   = (enable && p_v[LAT-1]) || inj_act;
  assign activations = inj_act ? inj_data : act_fn(p_d[LAT-1]);

  // Observation logs sampled on the falling edge
  int          cyc = 0, done_cnt = 0, act_cnt = 0, done_base = 0;
  logic [63:0] en_d [$];
  logic        en_sw [$];
  logic        en_sa [$];
  int          en_cyc [$];
  logic [63:0] got [$];
  logic [63:0] feed_q [$];

  always @(negedge clk) begin
    cyc++;
    if (enable) begin
      en_d.push_back(systolic_data); en_sw.push_back(start_weights);
      en_sa.push_back(start_array);  en_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (activated) act_cnt++;
    if (r_valid && r_ready) got.push_back(r_data);
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    en_d.delete(); en_sw.delete(); en_sa.delete(); en_cyc.delete(); got.delete();
  endtask

  task automatic build_job(input int n);
    feed_q.delete();
    for (int k = 0; k < 8; k++) feed_q.push_back(64'h0101_0101_0101_0101 * 64'(k + 1));
    for (int i = 0; i < n; i++) feed_q.push_back({$urandom, $urandom});
  endtask

  task automatic start_job(input int n, input logic [63:0] b, input logic [1:0] m);
    cmd_num_inputs = 7'(n); cmd_bias = b; cmd_mode = m; cmd_start = 1'b1;
    cur_n = n; done_base = done_cnt;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic feed(input int inj_at, input int rst_at);
    int   idx = 0;
    int   budget = 1000;
    logic tg = 1'b0;
    logic fire;
    bit   did = 1'b0;
    while (idx < feed_q.size() && budget > 0) begin
      budget--;
      if (idx == rst_at) begin s_valid = 1'b0; n_rst = 1'b0; return; end
      tg = ~tg;
      s_valid = (idx < 8) ? tg : ($urandom_range(0, 3) != 0);
      s_data  = feed_q[idx];
      if (idx == inj_at && !did) begin
        cmd_start = 1'b1; cmd_bias = {$urandom, $urandom}; cmd_num_inputs = 7'd5; did = 1'b1;
      end
      @(negedge clk);
      fire = s_valid && s_ready;
      tick();
      cmd_start = 1'b0;
      if (fire) idx++;
    end
    s_valid = 1'b0;
    chk("feed_complete", 64'(idx), 64'(feed_q.size()));
  endtask

  task automatic finish_job(input int n);
    int c = 0;
    r_ready = 1'b1;
    while (done_cnt == done_base && c < 600) begin tick(); c++; end
    chk("done_seen", 64'(done_cnt != done_base), 64'd1);
    repeat (3) tick();
    chk("done_once", 64'(done_cnt - done_base), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("enable_after_done", 64'(enable), 64'd0);
    c = 0;
    while (r_valid && c < 50) begin tick(); c++; end
    chk("results_count", 64'(got.size()), 64'(n));
    if (got.size() == n)
      for (int i = 0; i < n; i++) chk("result_data", got[i], act_fn(feed_q[8 + i]));
  endtask

  task automatic check_issue(input int n);
    int sw = 0, sa = 0, nz = 0;
    chk("issue_len", 64'(en_d.size() >= 8 + n), 64'd1);
    foreach (en_sw[i]) if (en_sw[i]) sw++;
    foreach (en_sa[i]) if (en_sa[i]) sa++;
    chk("start_w_once", 64'(sw), 64'd1);
    chk("start_a_once", 64'(sa), 64'd1);
    if (en_d.size() >= 8 + n) begin
      for (int i = 0; i < 8; i++) chk("weight_row", en_d[i], feed_q[i]);
      chk("weight_contig", 64'(en_cyc[7] - en_cyc[0]), 64'd7);
      chk("start_w_row0", 64'(en_sw[0]), 64'd1);
      for (int i = 0; i < n; i++) chk("input_row", en_d[8 + i], feed_q[8 + i]);
      chk("start_a_row0", 64'(en_sa[8]), 64'd1);
      for (int i = 8 + n; i < en_d.size(); i++) if (en_d[i] != '0) nz++;
      chk("flush_zero", 64'(nz), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] b1;
    int          a0, c;

    // Reset held with random inputs
    #1 n_rst = 1'b0;
    repeat (4) begin
      tick();
      cmd_start = 1'($urandom); cmd_num_inputs = 7'($urandom); cmd_bias = {$urandom, $urandom};
      cmd_mode = 2'($urandom); s_valid = 1'($urandom); s_data = {$urandom, $urandom};
      r_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_sys_data", systolic_data, 64'd0);
    chk("rst_bias_vec", bias_vec, 64'd0);
    chk("rst_mode", 64'(activation_mode), 64'd0);
    chk("rst_start_w", 64'(start_weights), 64'd0);
    chk("rst_start_a", 64'(start_array), 64'd0);
    chk("rst_enable", 64'(enable), 64'd0);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_r_data", r_data, 64'd0);
    cmd_start = 1'b0; s_valid = 1'b0; r_ready = 1'b0;
    cmd_num_inputs = '0; cmd_bias = '0; cmd_mode = '0;
    tick(); n_rst = 1'b1; tick();

    // N=3 job with gapped weight fill
    r_ready = 1'b1;
    build_job(3); clear_logs();
    start_job(3, 64'h1111_2222_3333_4444, 2'd1);
    chk("busy_on_start", 64'(busy), 64'd1);
    feed(-1, -1);
    finish_job(3);
    check_issue(3);
    chk("bias_latched", bias_vec, 64'h1111_2222_3333_4444);
    chk("mode_latched", 64'(activation_mode), 64'd1);

    // N=8 with results backed up: array stalls with 4 held, nothing dropped
    r_ready = 1'b0;
    build_job(8); clear_logs();
    a0 = act_cnt;
    start_job(8, {$urandom, $urandom}, 2'd2);
    feed(-1, -1);
    repeat (60) tick();
    chk("stall_held", 64'(act_cnt - a0), 64'd4);
    chk("stall_enable", 64'(enable), 64'd0);
    chk("stall_r_valid", 64'(r_valid), 64'd1);
    chk("stall_overflow", 64'(overflow), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_no_done", 64'(done_cnt - done_base), 64'd0);
    finish_job(8);
    check_issue(8);
    chk("n8_overflow", 64'(overflow), 64'd0);

    // Results arriving while idle are stored; a fifth one is dropped
    r_ready = 1'b0; clear_logs(); feed_q.delete();
    for (int i = 0; i < 5; i++) begin
      feed_q.push_back({$urandom, $urandom});
      inj_data = feed_q[i]; inj_act = 1'b1; tick(); inj_act = 1'b0;
    end
    tick();
    chk("idle_overflow", 64'(overflow), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    r_ready = 1'b1; c = 0;
    while (r_valid && c < 20) begin tick(); c++; end
    chk("idle_fifo_count", 64'(got.size()), 64'd4);
    if (got.size() == 4) for (int i = 0; i < 4; i++) chk("idle_fifo_data", got[i], feed_q[i]);

    // N=0 command is ignored and leaves overflow alone
    start_job(0, 64'hDEAD_BEEF_0000_0001, 2'd3);
    repeat (3) tick();
    chk("n0_busy", 64'(busy), 64'd0);
    chk("n0_s_ready", 64'(s_ready), 64'd0);
    chk("n0_overflow_kept", 64'(overflow), 64'd1);

    // N=4 job with a second command mid-stream
    build_job(4); clear_logs();
    b1 = {$urandom, $urandom};
    start_job(4, b1, 2'd2);
    chk("ovf_cleared", 64'(overflow), 64'd0);
    feed(10, -1);
    chk("inj_bias_kept", bias_vec, b1);
    chk("inj_mode_kept", 64'(activation_mode), 64'd2);
    chk("inj_busy", 64'(busy), 64'd1);
    finish_job(4);
    check_issue(4);

    // Reset pulse while input 2 is on offer
    build_job(5); clear_logs();
    start_job(5, {$urandom, $urandom}, 2'd1);
    feed(-1, 10);
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_enable", 64'(enable), 64'd0);
    chk("mid_rst_sys", systolic_data, 64'd0);
    chk("mid_rst_bias", bias_vec, 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_r_valid", 64'(r_valid), 64'd0);
    tick(); n_rst = 1'b1; tick();
    chk("post_rst_r_valid", 64'(r_valid), 64'd0);

    // Next job after the reset runs cleanly
    build_job(2); clear_logs();
    start_job(2, {$urandom, $urandom}, 2'd0);
    feed(-1, -1);
    finish_job(2);
    check_issue(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
